// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin arbiter/sequencer sharing one FP16 multiplier
// between two requesters. Operands and results pass through untouched.
// Optional macro FP16_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts
// with an FP16 NaN result and rsp_err=1 after TIMEOUT enabled cycles.
module fp16_mul_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic [1:0]  rsp_ready,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_result
);

    localparam logic [15:0] FP16_NAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant;
    logic       gnt_id;
    logic       last_grant;
    logic       timeout_hit;

`ifdef FP16_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] timeout_cnt;
    logic        rsp_err_q;

    // mul_done has priority over the watchdog when both land in one cycle
    assign timeout_hit = (state == WAIT) && !mul_done && (timeout_cnt == TIMEOUT_LAST);
    assign rsp_err     = rsp_err_q;

    // Watchdog counter (cleared in ISSUE, counts enabled WAIT cycles) and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            rsp_err_q   <= 1'b0;
        end else if (ena) begin
            if (state == ISSUE) begin
                timeout_cnt <= '0;
            end else if (state == WAIT) begin
                timeout_cnt <= timeout_cnt + 16'd1;
                if (mul_done) begin
                    rsp_err_q <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_err_q <= 1'b1;
                end
            end
        end
    end
`else
    // Without the watchdog the parameter has no effect; keep it referenced.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // State register; ena low freezes the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Round-robin grant, next-state and handshake outputs
    always_comb begin
        grant     = 2'b00;
        state_nxt = state;
        req_ready = 2'b00;
        mul_start = 1'b0;
        rsp_valid = 2'b00;

        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        case (state)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held
                req_ready = grant & {2{ena & rst_n}};
                if (grant != 2'b00) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = gnt_id ? 2'b10 : 2'b01;
                if (rsp_ready[gnt_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch on grant, result capture, and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_data   <= '0;
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_id <= grant[1];
                        mul_a  <= grant[1] ? req_a1 : req_a0;
                        mul_b  <= grant[1] ? req_b1 : req_b0;
                    end
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_data <= mul_result;
                    end else if (timeout_hit) begin
                        rsp_data <= FP16_NAN;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_id]) begin
                        last_grant <= gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed testbench for fp16_mul_arbiter. Inputs are driven on the falling
// edge and outputs are sampled 1ns later, away from the rising active edge.
module tb_fp16_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [1:0]  req_valid;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_ready;
    logic        mul_start;
    logic [15:0] mul_a, mul_b;
    logic        mul_done;
    logic [15:0] mul_result;

    int n_checks = 0;
    int n_pass   = 0;

    fp16_mul_arbiter #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction for requester k, starting at a falling edge in IDLE
    // with req_valid already driven. lat = cycles from mul_start to mul_done,
    // bp = RESP cycles with only the other requester's rsp_ready asserted.
    task automatic serve(input int k, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] res, input int lat, input int bp,
                         input bit drop, input string tag);
        logic [1:0] oh;
        oh = (k == 1) ? 2'b10 : 2'b01;
        #1 check({tag, "_ready"}, 16'(req_ready), 16'(oh));
        @(negedge clk);
        if (drop) req_valid = 2'b00;
        #1 check({tag, "_start"}, 16'(mul_start), 16'd1);
        check({tag, "_mul_a"}, mul_a, ea);
        check({tag, "_mul_b"}, mul_b, eb);
        repeat (lat) @(negedge clk);
        #1 check({tag, "_early_vld"}, 16'(rsp_valid), 16'd0);
        mul_done   = 1'b1;
        mul_result = res;
        @(negedge clk);
        mul_done   = 1'b0;
        mul_result = 16'h0000;
        #1 check({tag, "_rsp_vld"}, 16'(rsp_valid), 16'(oh));
        check({tag, "_rsp_data"}, rsp_data, res);
        check({tag, "_rsp_err"}, 16'(rsp_err), 16'd0);
        for (int i = 0; i < bp; i++) begin
            rsp_ready = ~oh;
            @(negedge clk);
            #1 check({tag, "_bp_vld"}, 16'(rsp_valid), 16'(oh));
            check({tag, "_bp_data"}, rsp_data, res);
            check({tag, "_bp_ready"}, 16'(req_ready), 16'd0);
        end
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check({tag, "_done_vld"}, 16'(rsp_valid), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; req_valid = 2'b00;
        req_a0 = 16'h0; req_b0 = 16'h0; req_a1 = 16'h0; req_b1 = 16'h0;
        rsp_ready = 2'b00; mul_done = 1'b0; mul_result = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 check("rst_rsp_vld", 16'(rsp_valid), 16'd0);
        check("rst_start", 16'(mul_start), 16'd0);
        check("rst_data", rsp_data, 16'd0);
        check("rst_mul_a", mul_a, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 1.0 * 2.0, done 3 cycles after start
        req_a0 = 16'h3C00; req_b0 = 16'h4000; req_valid = 2'b01;
        serve(0, 16'h3C00, 16'h4000, 16'h4000, 3, 0, 1'b1, "single");

        // Simultaneous requests held valid: 0, 1, 0 out of reset
        apply_reset();
        req_a0 = 16'h1111; req_b0 = 16'h2222; req_a1 = 16'h3333; req_b1 = 16'h4444;
        req_valid = 2'b11;
        serve(0, 16'h1111, 16'h2222, 16'hAAAA, 1, 0, 1'b0, "rr0");
        serve(1, 16'h3333, 16'h4444, 16'hBBBB, 2, 0, 1'b0, "rr1");
        serve(0, 16'h1111, 16'h2222, 16'hCCCC, 1, 0, 1'b0, "rr2");
        req_valid = 2'b00;

        // Backpressure: rsp_ready[0] low 5 cycles, rsp_ready[1] ignored
        @(negedge clk);
        req_a0 = 16'h4200; req_b0 = 16'h4400; req_valid = 2'b01;
        serve(0, 16'h4200, 16'h4400, 16'h4A00, 1, 5, 1'b0, "bp");
        req_valid = 2'b00;

        // Watchdog behaviour
        @(negedge clk);
        req_a0 = 16'h5000; req_b0 = 16'h5100; req_valid = 2'b01;
        #1 check("to_ready", 16'(req_ready), 16'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
`ifdef FP16_ARB_TIMEOUT_EN
        repeat (15) @(negedge clk);
        #1 check("to_pre_vld", 16'(rsp_valid), 16'd0);
        @(negedge clk);
        #1 check("to_vld", 16'(rsp_valid), 16'd1);
        check("to_data", rsp_data, 16'h7E00);
        check("to_err", 16'(rsp_err), 16'd1);
`else
        repeat (40) @(negedge clk);
        #1 check("nto_vld", 16'(rsp_valid), 16'd0);
        check("nto_start", 16'(mul_start), 16'd0);
        mul_done = 1'b1; mul_result = 16'h5D10;
        @(negedge clk);
        mul_done = 1'b0;
        #1 check("nto_late_vld", 16'(rsp_valid), 16'd1);
        check("nto_data", rsp_data, 16'h5D10);
        check("nto_err", 16'(rsp_err), 16'd0);
`endif
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;

        // Reset asserted in WAIT
        req_a0 = 16'h3800; req_b0 = 16'h3A00; req_valid = 2'b01;
        #1 check("rw_ready", 16'(req_ready), 16'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1 check("rw_rst_ready", 16'(req_ready), 16'd0);
        check("rw_rst_vld", 16'(rsp_valid), 16'd0);
        check("rw_rst_data", rsp_data, 16'd0);
        check("rw_rst_err", 16'(rsp_err), 16'd0);
        check("rw_rst_start", 16'(mul_start), 16'd0);
        check("rw_rst_mul_a", mul_a, 16'd0);
        check("rw_rst_mul_b", mul_b, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        mul_done = 1'b1; mul_result = 16'hABCD;
        @(negedge clk);
        mul_done = 1'b0;
        #1 check("rw_late_vld", 16'(rsp_valid), 16'd0);
        check("rw_late_start", 16'(mul_start), 16'd0);
        @(negedge clk);
        #1 check("rw_late_vld2", 16'(rsp_valid), 16'd0);
        req_a0 = 16'h3400; req_b0 = 16'h3500; req_a1 = 16'h3600; req_b1 = 16'h3700;
        req_valid = 2'b11;
        serve(0, 16'h3400, 16'h3500, 16'h2D40, 2, 0, 1'b1, "rw_next");

        // ena low for 4 cycles while in ISSUE
        @(negedge clk);
        req_a1 = 16'h5555; req_b1 = 16'h6666; req_valid = 2'b10;
        #1 check("ena_ready", 16'(req_ready), 16'd2);
        @(negedge clk);
        req_valid = 2'b00;
        ena = 1'b0;
        #1 check("ena_start0", 16'(mul_start), 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("ena_frozen_start", 16'(mul_start), 16'd1);
            check("ena_frozen_mul_a", mul_a, 16'h5555);
        end
        ena = 1'b1;
        @(negedge clk);
        #1 check("ena_wait_start", 16'(mul_start), 16'd0);
        check("ena_wait_vld", 16'(rsp_valid), 16'd0);
        mul_done = 1'b1; mul_result = 16'h7123;
        @(negedge clk);
        mul_done = 1'b0;
        #1 check("ena_rsp_vld", 16'(rsp_valid), 16'd2);
        check("ena_rsp_data", rsp_data, 16'h7123);
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check("ena_done_vld", 16'(rsp_valid), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
